// File: rtl/data_cache_2way.sv
// 2-way set-associative write-back, write-allocate data cache with per-set LRU.
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module data_cache_2way #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          read,
    input  logic                          write,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             writedata,
    output logic [DATA_W-1:0]             readdata,
    output logic                          busywait,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-OFFSET_W-1:0]    mem_address,
    output logic [(DATA_W<<OFFSET_W)-1:0] mem_writedata,
    input  logic [(DATA_W<<OFFSET_W)-1:0] mem_readdata,
    input  logic                          mem_busywait
`ifdef CACHE_STATS_EN
   ,output logic [15:0]                   hit_count,
    output logic [15:0]                   miss_count
`endif
);

    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W = DATA_W << OFFSET_W;
    localparam int SETS    = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH} state_t;

    state_t state, next_state;

    logic [BLOCK_W-1:0]  blk   [2][SETS];
    logic [TAG_W-1:0]    tags  [2][SETS];
    logic [SETS-1:0]     valid [2];
    logic [SETS-1:0]     dirty [2];
    logic [SETS-1:0]     lru;
    logic                victim;
    logic                refill_retry;

    logic [TAG_W-1:0]    atag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic                req, hit0, hit1, hit, hit_way, miss_victim, fill;

    assign atag    = address[ADDR_W-1 -: TAG_W];
    assign idx     = address[OFFSET_W +: INDEX_W];
    assign off     = address[OFFSET_W-1:0];
    assign req     = read | write;
    assign hit0    = valid[0][idx] && (tags[0][idx] == atag);
    assign hit1    = valid[1][idx] && (tags[1][idx] == atag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;
    assign fill    = (state == FETCH) && !mem_busywait;

    // Invalid ways are filled first (way 0 preferred), otherwise the LRU way.
    assign miss_victim = !valid[0][idx] ? 1'b0 :
                         !valid[1][idx] ? 1'b1 : lru[idx];

    assign busywait = req && !((state == IDLE) && hit);

    always_comb begin
        readdata = '0;
        if (hit) readdata = blk[hit_way][idx][int'(off)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state)
            IDLE: begin
                if (req && !hit)
                    next_state = dirty[miss_victim][idx] ? WRITE_BACK : FETCH;
            end
            WRITE_BACK: begin
                mem_write     = 1'b1;
                mem_address   = {tags[victim][idx], idx};
                mem_writedata = blk[victim][idx];
                if (!mem_busywait) next_state = FETCH;
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {atag, idx};
                if (!mem_busywait) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid[0]     <= '0;
            valid[1]     <= '0;
            dirty[0]     <= '0;
            dirty[1]     <= '0;
            lru          <= '0;
            victim       <= 1'b0;
            refill_retry <= 1'b0;
        end else if (state == IDLE) begin
            refill_retry <= 1'b0;
            if (req && !hit) victim <= miss_victim;
            if (req && hit) begin
                lru[idx] <= ~hit_way;
                if (write) dirty[hit_way][idx] <= 1'b1;
            end
        end else if (fill) begin
            valid[victim][idx] <= 1'b1;
            dirty[victim][idx] <= 1'b0;
            lru[idx]           <= ~victim;
            refill_retry       <= 1'b1;
        end
    end

    // Line storage carries no reset; a reset edge simply blocks any update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state == IDLE) && write && hit)
                blk[hit_way][idx][int'(off)*DATA_W +: DATA_W] <= writedata;
            if (fill) begin
                blk[victim][idx]  <= mem_readdata;
                tags[victim][idx] <= atag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // The hit that retires a request right after its fill belongs to the miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && req) begin
            if (hit && !refill_retry && hit_count != '1) hit_count <= hit_count + 16'd1;
            if (!hit && miss_count != '1) miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_2way.sv
module tb_data_cache_2way;

  logic        clk = 1'b0;
  logic        reset, read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  data_cache_2way #(.ADDR_W(8), .DATA_W(8), .OFFSET_W(2), .INDEX_W(2)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef CACHE_STATS_EN
   ,.hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [31:0] backing [64];
  int          lat_cfg, wait_left, fetch_cnt, wb_cnt;
  bit          pend, pend_wr;
  logic [5:0]  cap_addr;
  logic [31:0] cap_data;

  logic [7:0]  gold [256];
  logic [3:0]  mru [4][2];
  int          n_res [4];
  bit          dirty_blk [64];
  int          hits_m, misses_m;

  task automatic tally(input bit ok, input string tag);
    checks++;
    if (ok) passes++;
    else $error("FAIL %s", tag);
  endtask

  function automatic logic [31:0] gold_blk(input int b);
    return {gold[4*b+3], gold[4*b+2], gold[4*b+1], gold[4*b]};
  endfunction

  task automatic reload_model();
    for (int unsigned i = 0; i < 256; i++) gold[i] = backing[i/4][(i%4)*8 +: 8];
    for (int unsigned s = 0; s < 4; s++) n_res[s] = 0;
    for (int unsigned b = 0; b < 64; b++) dirty_blk[b] = 1'b0;
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (pend) begin
      if (pend_wr) begin
        backing[cap_addr] = cap_data;
        wb_cnt++;
      end else begin
        fetch_cnt++;
      end
      pend = 1'b0;
      mem_busywait = 1'b1;
      wait_left = lat_cfg;
    end
    if (mem_read || mem_write) begin
      if (wait_left <= 1) begin
        mem_busywait = 1'b0;
        pend     = 1'b1;
        pend_wr  = mem_write;
        cap_addr = mem_address;
        cap_data = mem_writedata;
        mem_readdata = backing[mem_address];
      end else begin
        wait_left--;
      end
    end else begin
      mem_busywait = 1'b1;
      wait_left = lat_cfg;
    end
  endtask

  task automatic do_access(input bit is_wr, input bit both, input logic [7:0] a,
                           input logic [7:0] wd);
    logic [1:0]  s;
    logic [3:0]  t, ev_tag;
    logic [5:0]  b, ev_blk;
    logic        exp_hit, exp_wb;
    logic [31:0] exp_wdata;
    int          f0, w0, cyc;
    s = a[3:2];
    t = a[7:4];
    b = a[7:2];
    exp_hit = (n_res[s] > 0 && mru[s][0] == t) || (n_res[s] > 1 && mru[s][1] == t);
    ev_tag  = mru[s][1];
    ev_blk  = {ev_tag, s};
    exp_wb  = !exp_hit && n_res[s] == 2 && dirty_blk[ev_blk];
    exp_wdata = gold_blk(int'(ev_blk));
    f0 = fetch_cnt;
    w0 = wb_cnt;

    read = !is_wr || both;
    write = is_wr;
    address = a;
    writedata = wd;
    #1;
    tally(busywait === !exp_hit, "busy_first");
    if (exp_hit) begin
      hits_m++;
      if (!is_wr) tally(readdata === gold[a], "rd_hit_data");
    end else begin
      misses_m++;
      cyc = 0;
      while (busywait && cyc < 100) begin
        step_cycle();
        cyc++;
        tally((mem_read && mem_write) === 1'b0, "rd_wr_exclusive");
        if (mem_write) begin
          tally(mem_address === ev_blk, "wb_addr");
          tally(mem_writedata === exp_wdata, "wb_data");
        end
        if (mem_read) tally(mem_address === b, "fetch_addr");
      end
      tally(busywait === 1'b0, "miss_timeout");
      if (!is_wr) tally(readdata === gold[a], "rd_miss_data");
    end
    step_cycle();
    read = 1'b0;
    write = 1'b0;
    tally((fetch_cnt - f0) == (exp_hit ? 0 : 1), "fetch_count");
    tally((wb_cnt - w0) == (exp_wb ? 1 : 0), "wb_count");

    if (exp_wb) dirty_blk[ev_blk] = 1'b0;
    if (exp_hit) begin
      if (mru[s][0] != t) begin
        mru[s][1] = mru[s][0];
        mru[s][0] = t;
      end
    end else begin
      if (n_res[s] > 0) mru[s][1] = mru[s][0];
      mru[s][0] = t;
      if (n_res[s] < 2) n_res[s]++;
    end
    if (is_wr) begin
      gold[a] = wd;
      dirty_blk[b] = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    lat_cfg = 5;
    wait_left = 5;
    fetch_cnt = 0;
    wb_cnt = 0;
    pend = 1'b0;
    pend_wr = 1'b0;
    cap_addr = '0;
    cap_data = '0;
    for (int unsigned i = 0; i < 64; i++) backing[i] = $urandom;
    backing[0] = 32'h44332211;
    reload_model();

    step_cycle();
    step_cycle();
    reset = 1'b0;
    #1;
    tally(busywait === 1'b0, "rst_busywait");
    tally(mem_read === 1'b0, "rst_mem_read");
    tally(mem_write === 1'b0, "rst_mem_write");
    tally(readdata === 8'h00, "rst_readdata");
    tally(mem_address === 6'h00, "rst_mem_address");
    tally(mem_writedata === 32'h0, "rst_mem_writedata");

    do_access(1'b0, 1'b0, 8'h00, 8'h00);
    tally(readdata === 8'h11, "cold_read_0x00");
    do_access(1'b0, 1'b0, 8'h03, 8'h00);
    do_access(1'b0, 1'b0, 8'h13, 8'h00);
    do_access(1'b1, 1'b0, 8'h13, 8'hAA);
    do_access(1'b0, 1'b0, 8'h13, 8'h00);
    tally(gold[8'h13] === 8'hAA, "gold_0x13");
    do_access(1'b0, 1'b0, 8'h10, 8'h00);
    do_access(1'b0, 1'b0, 8'h20, 8'h00);
    do_access(1'b0, 1'b0, 8'h30, 8'h00);
    tally(backing[6'h04][31:24] === gold[8'h13], "wb_landed");
    tally(backing[6'h04][31:24] === 8'hAA, "wb_aa_byte");
`ifdef CACHE_STATS_EN
    tally(hit_count === 16'(hits_m), "stats_hits_directed");
    tally(miss_count === 16'(misses_m), "stats_misses_directed");
`endif

    read = 1'b1;
    address = 8'h00;
    #1;
    tally(busywait === 1'b1, "pre_rst_busy");
    step_cycle();
    tally(mem_read === 1'b1, "pre_rst_fetch");
    tally(mem_address === 6'h00, "pre_rst_fetch_addr");
    reset = 1'b1;
    step_cycle();
    read = 1'b0;
    reset = 1'b0;
    #1;
    tally(mem_read === 1'b0, "post_rst_mem_read");
    tally(mem_write === 1'b0, "post_rst_mem_write");
    tally(busywait === 1'b0, "post_rst_busywait");
    reload_model();
    do_access(1'b0, 1'b0, 8'h00, 8'h00);
`ifdef CACHE_STATS_EN
    tally(hit_count === 16'(hits_m), "stats_after_reset_hits");
    tally(miss_count === 16'(misses_m), "stats_after_reset_misses");
`endif

    for (int unsigned n = 0; n < 300; n++) begin
      bit         wr;
      logic [7:0] a, d;
      lat_cfg = int'($urandom_range(1, 4));
      wr = $urandom_range(0, 1) == 1;
      a = 8'($urandom_range(0, 63));
      d = 8'($urandom);
      do_access(wr, wr && ($urandom_range(0, 3) == 0), a, d);
    end
`ifdef CACHE_STATS_EN
    tally(hit_count === 16'(hits_m), "stats_final_hits");
    tally(miss_count === 16'(misses_m), "stats_final_misses");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
